breath_envelope_gen: RTL and testbench
======================================

// Module: breath_envelope_gen
// PURPOSE
//  Generates the slowly varying duty-cycle envelope that drives the PWM stage of the breathing LED.
//  Duty cycle ramps up, holds at the top, ramps down, then holds at the bottom, and repeats.
//  A prescaler sets the envelope rate; each duty update is flagged by a single-cycle strobe.
//  Sits directly upstream of the PWM generator, which consumes duty/duty_upd.
// PARAMETERS
//  DUTY_W     4..8,  default 8      width of duty output
//  DUTY_MAX   default 2**DUTY_W-1   envelope ceiling; must be >= 1 and <= 2**DUTY_W-1
//  PRESCALE_W default 16            width of prescaler counter
//  PRESCALE   default 50000         clk cycles per envelope tick; must be >= 2 and < 2**PRESCALE_W
//  HOLD_HI    default 16            ticks held at DUTY_MAX; must be >= 1
//  HOLD_LO    default 32            ticks held at 0; must be >= 1
// PORTS
//  clk       in   1        single system clock
//  rst       in   1        asynchronous, active-LOW reset (asserted when 0)
//  en        in   1        1 = run; 0 = freeze prescaler, state and duty
//  speed     in   2        step size per tick: 0->1, 1->2, 2->4, 3->8
//  duty      out  DUTY_W   current duty value to the PWM stage
//  duty_upd  out  1        1-cycle strobe: duty register written on the preceding edge
//  phase     out  2        current envelope state (encoding per package)
// BEHAVIOUR
//  Reset (rst=0, async): duty=0, duty_upd=0, phase=RISE, prescaler=0, hold_cnt=0. Effect is immediate.
//  Prescaler
//   - Counts 0..PRESCALE-1 while en=1, then wraps to 0.
//   - tick = en && (cnt==PRESCALE-1); one tick every PRESCALE enabled cycles.
//   - en=0: cnt holds and no tick is produced.
//  On the clock edge where tick=1, state and duty update, and duty_upd=1 for exactly the following cycle.
//  duty_upd pulses on every tick, including hold ticks. Latency from tick to visible duty: 1 edge.
//  speed is sampled at each tick; a mid-ramp change takes effect on the next tick.
//  Arithmetic is DUTY_W+1 bits wide with saturation; no wrap-around is ever permitted.
//  FSM transitions (evaluated on tick only):
//   - RISE: if duty+step >= DUTY_MAX, then duty=DUTY_MAX, hold_cnt=0, go to HOLD_HI;
//     otherwise duty+=step.
//   - HOLD_HI: duty unchanged. If hold_cnt==HOLD_HI-1, go to FALL; otherwise hold_cnt++.
//   - FALL: if duty <= step, then duty=0, hold_cnt=0, go to HOLD_LO; otherwise duty-=step.
//   - HOLD_LO: duty unchanged. If hold_cnt==HOLD_LO-1, go to RISE; otherwise hold_cnt++.
//  en falling mid-operation freezes everything exactly. The first tick after re-enable occurs
//  after the remaining PRESCALE-1-cnt cycles.
//  Reset asserted mid-operation: immediate return to reset values; the ramp restarts from 0
//  after release.
//  Full period at step s (with DUTY_MAX divisible by s):
//   (2*DUTY_MAX/s + HOLD_HI + HOLD_LO) ticks.
// STRUCTURE
//  Package breath_pkg:
//   - phase encoding: RISE=2'd0, HOLD_HI=2'd1, FALL=2'd2, HOLD_LO=2'd3
//   - function speed_to_step(speed) -> 1 << speed
//  Sub-module breath_prescaler (clk, rst, en -> tick), parameterised by PRESCALE_W/PRESCALE.
//  FSM, duty datapath, hold counter and strobe register remain in this module.
// TESTING  (bench params: DUTY_W=4, DUTY_MAX=15, PRESCALE=4, HOLD_HI=2, HOLD_LO=3)
//  1. Reset release, en=1, speed=0
//     -> duty=0, phase=RISE, duty_upd=0 at reset.
//     -> first duty_upd 4 cycles after release, with duty=1.
//  2. speed=3
//     -> duty sequence per tick 8, 15 (HOLD_HI), 15, 15, 7, 0 (HOLD_LO), 0, 0, 0, then RISE 8.
//  3. speed=0, full period
//     -> 35 duty_upd pulses every 140 clk cycles; duty peaks at 15 and never exceeds it.
//  4. en=0 for 10 cycles at duty=6 with cnt=2
//     -> duty, phase and duty_upd frozen.
//     -> after en=1, next tick occurs 2 cycles later.
//  5. speed 0->2 at duty=5 in RISE
//     -> next tick gives duty=9, then 13, then 15 (saturated, HOLD_HI).
//  6. rst=0 pulse between clock edges during FALL
//     -> duty=0, phase=RISE, duty_upd=0 before the next clk edge.

Source files
------------

// File: rtl/breath_pkg.sv
// Shared definitions for the breathing-LED envelope generator:
// envelope phase encoding and the speed-to-step mapping.
package breath_pkg;

    // Envelope phase, visible on the phase output of breath_envelope_gen.
    typedef enum logic [1:0] {
        PH_RISE    = 2'd0,
        PH_HOLD_HI = 2'd1,
        PH_FALL    = 2'd2,
        PH_HOLD_LO = 2'd3
    } phase_t;

    // Widest step is 8, so four bits hold every step size.
    localparam int STEP_W = 4;

    // Duty increment per tick: 0->1, 1->2, 2->4, 3->8.
    function automatic logic [STEP_W-1:0] speed_to_step(input logic [1:0] speed);
        return STEP_W'(1) << speed;
    endfunction

endpackage

// File: rtl/breath_prescaler.sv
// Envelope-rate prescaler: produces a one-cycle tick every PRESCALE
// enabled clock cycles. Dropping en freezes the count in place, so the
// first tick after re-enable arrives after the cycles still outstanding.
module breath_prescaler #(
    parameter int PRESCALE_W = 16,
    parameter int PRESCALE   = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] CNT_LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] cnt_q;

    assign tick = en && (cnt_q == CNT_LAST);

    // Count 0..PRESCALE-1 while enabled, wrap to 0, hold while disabled.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!rst) begin
            cnt_q <= '0;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/breath_envelope_gen.sv
// Breathing-LED duty envelope: ramps duty up to DUTY_MAX, holds, ramps down
// to 0, holds, and repeats. Each envelope tick updates the state and duty
// registers and raises duty_upd for the following cycle, so the downstream
// PWM stage knows when a fresh duty value is available.
module breath_envelope_gen
    import breath_pkg::*;
#(
    parameter int DUTY_W     = 8,
    parameter int DUTY_MAX   = 2**DUTY_W - 1,
    parameter int PRESCALE_W = 16,
    parameter int PRESCALE   = 50000,
    parameter int HOLD_HI    = 16,
    parameter int HOLD_LO    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        speed,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic [1:0]        phase
);

    // One extra bit lets duty+step be compared against the ceiling without
    // wrapping, which is what makes the rising saturation exact.
    localparam int WIDE_W   = DUTY_W + 1;
    localparam int HOLD_MAX = (HOLD_HI > HOLD_LO) ? HOLD_HI : HOLD_LO;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DUTY_W-1:0] DUTY_TOP     = DUTY_W'(DUTY_MAX);
    localparam logic [WIDE_W-1:0] DUTY_TOP_W   = WIDE_W'(DUTY_MAX);
    localparam logic [HOLD_W-1:0] HOLD_HI_LAST = HOLD_W'(HOLD_HI - 1);
    localparam logic [HOLD_W-1:0] HOLD_LO_LAST = HOLD_W'(HOLD_LO - 1);

    logic              tick;
    phase_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [DUTY_W-1:0] step;
    logic [WIDE_W-1:0] rise_sum;
    logic              rise_sat;
    logic              fall_floor;

    breath_prescaler #(
        .PRESCALE_W (PRESCALE_W),
        .PRESCALE   (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // Step size is sampled every tick, so a speed change lands on the next tick.
    assign step       = DUTY_W'(speed_to_step(speed));
    assign rise_sum   = {1'b0, duty_q} + {1'b0, step};
    assign rise_sat   = (rise_sum >= DUTY_TOP_W);
    // Falling saturates at 0: any duty not above the step lands on the floor.
    assign fall_floor = (duty_q <= step);

    // Next-state and duty datapath; nothing moves except on a tick.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;

        if (tick) begin
            unique case (state_q)
                PH_RISE: begin
                    if (rise_sat) begin
                        duty_d  = DUTY_TOP;
                        hold_d  = '0;
                        state_d = PH_HOLD_HI;
                    end else begin
                        duty_d = rise_sum[DUTY_W-1:0];
                    end
                end
                PH_HOLD_HI: begin
                    if (hold_q == HOLD_HI_LAST) begin
                        state_d = PH_FALL;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                PH_FALL: begin
                    if (fall_floor) begin
                        duty_d  = '0;
                        hold_d  = '0;
                        state_d = PH_HOLD_LO;
                    end else begin
                        duty_d = duty_q - step;
                    end
                end
                PH_HOLD_LO: begin
                    if (hold_q == HOLD_LO_LAST) begin
                        state_d = PH_RISE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            endcase
        end
    end

    // State, duty, hold counter and update strobe registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= PH_RISE;
            duty_q   <= '0;
            hold_q   <= '0;
            duty_upd <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            hold_q   <= hold_d;
            duty_upd <= tick;
        end
    end

    assign duty  = duty_q;
    assign phase = state_q;

endmodule

// File: tb/tb_breath_envelope_gen.sv
// Directed bench for breath_envelope_gen with a small, fast envelope:
// DUTY_W=4, DUTY_MAX=15, PRESCALE=4, HOLD_HI=2, HOLD_LO=3.
module tb_breath_envelope_gen;
    import breath_pkg::*;

    localparam int DUTY_W   = 4;
    localparam int DUTY_MAX = 15;
    localparam int PRESCALE = 4;
    localparam int HOLD_HI  = 2;
    localparam int HOLD_LO  = 3;

    logic              clk;
    logic              rst;
    logic              en;
    logic [1:0]        speed;
    logic [DUTY_W-1:0] duty;
    logic              duty_upd;
    logic [1:0]        phase;

    int n_cmp  = 0;
    int n_fail = 0;

    // speed=3 from reset: duty and phase after each of the first ten ticks.
    logic [3:0] t2_duty [10] = '{4'd8, 4'd15, 4'd15, 4'd15, 4'd7,
                                 4'd0, 4'd0,  4'd0,  4'd0,  4'd8};
    phase_t     t2_ph   [10] = '{PH_RISE, PH_HOLD_HI, PH_HOLD_HI, PH_FALL, PH_FALL,
                                 PH_HOLD_LO, PH_HOLD_LO, PH_HOLD_LO, PH_RISE, PH_RISE};

    breath_envelope_gen #(
        .DUTY_W     (DUTY_W),
        .DUTY_MAX   (DUTY_MAX),
        .PRESCALE_W (16),
        .PRESCALE   (PRESCALE),
        .HOLD_HI    (HOLD_HI),
        .HOLD_LO    (HOLD_LO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .speed    (speed),
        .duty     (duty),
        .duty_upd (duty_upd),
        .phase    (phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance whole cycles; always return just after a falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Wait (bounded) for the next duty_upd pulse; reports cycles waited.
    task automatic wait_upd(input string tag, output int cycles);
        cycles = 0;
        do begin
            step(1);
            cycles++;
        end while (duty_upd !== 1'b1 && cycles < 4 * PRESCALE);
        check({tag, "_upd"}, 32'(duty_upd), 32'd1);
    endtask

    // Pulse reset between clock edges and release on the next falling edge.
    task automatic do_reset();
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int cyc;
        int pulses;
        int peak;

        rst   = 1'b0;
        en    = 1'b0;
        speed = 2'd0;
        step(2);

        // 1: reset values, then first tick 4 cycles after release with duty=1.
        check("t1_rst_duty",  32'(duty),     32'd0);
        check("t1_rst_phase", 32'(phase),    32'(PH_RISE));
        check("t1_rst_upd",   32'(duty_upd), 32'd0);
        en  = 1'b1;
        rst = 1'b1;
        wait_upd("t1_first", cyc);
        check("t1_latency", 32'(cyc),   32'd4);
        check("t1_duty",    32'(duty),  32'd1);
        check("t1_phase",   32'(phase), 32'(PH_RISE));
        step(1);
        check("t1_strobe_width", 32'(duty_upd), 32'd0);

        // 2: speed=3 from 0 through a whole envelope and into the next rise.
        speed = 2'd3;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wait_upd($sformatf("t2_tick%0d", i), cyc);
            check($sformatf("t2_gap%0d", i),   32'(cyc),   32'd4);
            check($sformatf("t2_duty%0d", i),  32'(duty),  32'(t2_duty[i]));
            check($sformatf("t2_phase%0d", i), 32'(phase), 32'(t2_ph[i]));
        end

        // 3: speed=0 full period: 35 ticks in 140 cycles, peak exactly 15.
        speed = 2'd0;
        do_reset();
        pulses = 0;
        peak   = 0;
        repeat (140) begin
            step(1);
            if (duty_upd === 1'b1) pulses++;
            if (int'(duty) > peak) peak = int'(duty);
        end
        check("t3_pulses",    32'(pulses), 32'd35);
        check("t3_peak",      32'(peak),   32'd15);
        check("t3_end_duty",  32'(duty),   32'd0);
        check("t3_end_phase", 32'(phase),  32'(PH_RISE));

        // 4: freeze at duty=6 with prescaler at 2; resume ticks 2 cycles later.
        for (int i = 1; i <= 6; i++) begin
            wait_upd($sformatf("t4_ramp%0d", i), cyc);
            check($sformatf("t4_ramp_duty%0d", i), 32'(duty), 32'(i));
        end
        step(2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check($sformatf("t4_frz_duty%0d", i),  32'(duty),     32'd6);
            check($sformatf("t4_frz_phase%0d", i), 32'(phase),    32'(PH_RISE));
            check($sformatf("t4_frz_upd%0d", i),   32'(duty_upd), 32'd0);
        end
        en = 1'b1;
        wait_upd("t4_resume", cyc);
        check("t4_resume_gap",  32'(cyc),  32'd2);
        check("t4_resume_duty", 32'(duty), 32'd7);

        // 5: speed 0->2 at duty=5 mid-rise: 9, 13, then saturate at 15.
        speed = 2'd0;
        do_reset();
        repeat (5) wait_upd("t5_pre", cyc);
        check("t5_start_duty", 32'(duty), 32'd5);
        speed = 2'd2;
        wait_upd("t5_a", cyc);
        check("t5_duty9",   32'(duty),  32'd9);
        check("t5_phase9",  32'(phase), 32'(PH_RISE));
        wait_upd("t5_b", cyc);
        check("t5_duty13",  32'(duty),  32'd13);
        wait_upd("t5_c", cyc);
        check("t5_duty15",  32'(duty),  32'd15);
        check("t5_phase15", 32'(phase), 32'(PH_HOLD_HI));

        // 6: continue to FALL, then assert reset between edges while duty_upd=1.
        wait_upd("t6_hold", cyc);
        check("t6_hold_phase", 32'(phase), 32'(PH_HOLD_HI));
        wait_upd("t6_fall0", cyc);
        check("t6_fall0_phase", 32'(phase), 32'(PH_FALL));
        check("t6_fall0_duty",  32'(duty),  32'd15);
        wait_upd("t6_fall1", cyc);
        check("t6_fall1_duty",  32'(duty),  32'd11);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_duty",  32'(duty),     32'd0);
        check("t6_rst_phase", 32'(phase),    32'(PH_RISE));
        check("t6_rst_upd",   32'(duty_upd), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_upd("t6_restart", cyc);
        check("t6_restart_gap",  32'(cyc),  32'd4);
        check("t6_restart_duty", 32'(duty), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
